// File: rtl/display_scan_mux_if.sv
// Display feed bundle: load/value from the producer, scanned digit outputs back.
// The scanner owns the slave side; the producer or bench owns the master side.
interface display_scan_mux_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [3:0]            bcd;
  logic [DIGITS-1:0]     digit_en;
  logic                  blank;
  logic                  busy;

  modport master (
    output load, value,
    input  bcd, digit_en, blank, busy
  );

  modport slave (
    input  load, value,
    output bcd, digit_en, blank, busy
  );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed hex scanner with double-buffered value, applied only at scan wrap.
// Optional leading-zero blanking when DISPLAY_SCAN_MUX_LZB_EN is defined.
module display_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int GAP      = 2
) (
  input  logic               clk,
  input  logic               nreset,
  display_scan_mux_if.slave  bus
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [VW-1:0]     disp;
  logic [VW-1:0]     pend;
  logic              pending;
  logic              tick;
  logic              wrap;
  logic [DIGITS-1:0] sup;
  logic [3:0]        nib;
  logic              sup_cur;
  logic              lit;

  assign tick = (cnt == CW'(PRESCALE - 1));
  assign wrap = tick && (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt     <= '0;
      idx     <= '0;
      disp    <= '0;
      pend    <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end
      // A load landing on the wrap cycle goes straight to the display and drops any pending value.
      if (wrap && bus.load) begin
        disp    <= bus.value;
        pending <= 1'b0;
      end else if (wrap && pending) begin
        disp    <= pend;
        pending <= 1'b0;
      end else if (!wrap && bus.load) begin
        pend    <= bus.value;
        pending <= 1'b1;
      end
    end
  end

`ifdef DISPLAY_SCAN_MUX_LZB_EN
  logic upper_zero;

  always_comb begin
    sup        = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (disp[4*i +: 4] == 4'h0);
      sup[i]     = upper_zero;
    end
  end
`else
  assign sup = '0;
`endif

  always_comb begin
    nib     = '0;
    sup_cur = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib     = disp[4*i +: 4];
        sup_cur = sup[i];
      end
    end
  end

  // Gating with nreset keeps every digit dark during reset even for a zero-length gap.
  assign lit = nreset && (cnt >= CW'(GAP)) && !sup_cur;

  always_comb begin
    bus.digit_en = '1;
    for (int i = 0; i < DIGITS; i++) begin
      bus.digit_en[i] = ~(lit && (idx == IW'(i)));
    end
  end

  assign bus.bcd   = nib;
  assign bus.blank = ~lit;
  assign bus.busy  = pending;
endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Upstream feeder for the seven-segment decoder.
- Holds a multi-digit hex value and time-multiplexes it onto one shared 4-bit nibble bus. That bus drives the decoder's bcd input.
- Generates active-low one-hot digit strobes with an anti-ghosting blank gap.
- New values are double-buffered and applied only at scan wrap, so a displayed frame never tears.

Parameters:
- DIGITS, 4: number of display digits. Value width is 4*DIGITS.
- PRESCALE, 1000: clock cycles per digit slot. Must be >= 2.
- GAP, 2: cycles at the start of each slot with all digits off. Must be < PRESCALE.

Ports:
- clk  input  1  system clock, rising edge.
- nreset  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle strobe; capture value.
- value  input  4*DIGITS  new display value; nibble 0 (value[3:0]) is the rightmost digit.
- bcd  output  4  nibble for the current digit; connects to the decoder's bcd input.
- digit_en  output  DIGITS  active-low one-hot digit strobe.
- blank  output  1  high when no digit is enabled.
- busy  output  1  high while a pending value awaits scan wrap.

Behaviour:
- Reset (nreset low, asynchronous, any time including mid-scan):
  - cnt=0, idx=0, disp=0, pend=0, busy=0.
  - Outputs immediately: digit_en = all ones, bcd=0, blank=1.
- Prescaler cnt counts 0..PRESCALE-1, then wraps to 0. tick = (cnt==PRESCALE-1).
- On tick: idx advances idx+1, wrapping DIGITS-1 -> 0.
- wrap = tick && idx==DIGITS-1.
- Outputs are decoded directly from the state registers; there is no extra pipeline stage.
  - bcd = disp[4*idx+3 : 4*idx], held for the whole slot, including the gap.
  - cnt < GAP: digit_en = all ones, blank=1.
  - cnt >= GAP: digit_en = ~(1<<idx), blank=0.
- Update handshake, evaluated each clock:
  - wrap && load: disp<=value, busy<=0. The pending value is discarded.
  - wrap && !load && busy: disp<=pend, busy<=0.
  - !wrap && load: pend<=value, busy<=1. Last load wins; an earlier pending value is overwritten without error.
  - Otherwise: hold.
- A new disp first appears in slot 0 of the next scan. Worst-case latency from load to visible is DIGITS*PRESCALE + GAP cycles.
- Per-slot timing: GAP cycles dark, then PRESCALE-GAP cycles lit. One full frame is DIGITS*PRESCALE cycles.
- load is ignored while nreset is low.
- value is sampled only in the cycle load is high.

Optional Feature:
- Macro: DISPLAY_SCAN_MUX_LZB_EN (leading-zero blanking).
- With the macro defined:
  - Any digit i > 0 for which disp nibbles i..DIGITS-1 are all zero is suppressed for its whole slot: digit_en all ones, blank=1, bcd still driven.
  - Digit 0 is never suppressed.
  - Suppression is computed from disp, so it changes only at wrap.
- Without the macro: every digit is lit during its non-gap cycles, per the rules above.

Test Plan (DIGITS=4, PRESCALE=8, GAP=2):
1. Reset mid-slot:
   - Stimulus: nreset low at idx=2, cnt=5.
   - Response: same cycle, digit_en=4'b1111, bcd=0, blank=1, busy=0.
   - After release, cnt counts from 0 with idx=0.
2. Scan timing:
   - Stimulus: load 0x1234 on the first wrap.
   - Response: next frame, slot 0 is dark for cycles 0-1, then digit_en=4'b1110 with bcd=4 for cycles 2-7.
   - Slot 1 gives 4'b1101/bcd=3; slot 2 gives 4'b1011/bcd=2; slot 3 gives 4'b0111/bcd=1; then repeat.
3. Mid-scan load:
   - Stimulus: load 0xABCD at idx=1.
   - Response: busy=1 next cycle; display keeps 0x1234 through slot 3.
   - At wrap, busy=0; the next frame shows D, C, B, A.
4. Double load:
   - Stimulus: load 0x1111 at idx=0, then 0x2222 at idx=2, both before wrap.
   - Response: the next frame shows bcd=2 in every slot; 0x1111 is never displayed.
5. Load on the wrap cycle:
   - Stimulus: load 0x5A5A exactly at idx=3, cnt=7, with an older pending 0x9999 held.
   - Response: disp=0x5A5A immediately, busy=0; 0x9999 is never shown.
6. Leading-zero blanking (DISPLAY_SCAN_MUX_LZB_EN defined):
   - Stimulus: value 0x0050.
   - Response: slots 3 and 2 stay fully dark; slot 1 lights with bcd=5; slot 0 lights with bcd=0.
   - Stimulus: value 0x0000. Response: only slot 0 lights.
   - Without the macro, all four slots light.
